// File: rtl/message_pkg.sv
// ----------------------------------------------------------------------------
// message_pkg
// Shared widths and the framing state type used by message_strip and
// message_build.
//   BLOCK_W   : padded SHA-2 block width
//   LEN_W     : width of the trailing message-length field
//   PAD_LIMIT : largest residue r (exclusive) that fits the length field
//               in the same block as the final data bits
// ----------------------------------------------------------------------------
package message_pkg;

   localparam int unsigned BLOCK_W   = 512;
   localparam int unsigned LEN_W     = 64;
   localparam int unsigned PAD_LIMIT = 448;
   localparam int unsigned R_W       = $clog2(BLOCK_W);

   typedef enum logic [1:0] {
      ST_EMPTY     = 2'd0,
      ST_HELD      = 2'd1,
      ST_LAST_PEND = 2'd2
   } msg_state_t;

   // Blocks a correctly padded message of len bits occupies:
   // ceil((len + 1 + LEN_W) / BLOCK_W), computed one bit wider to avoid wrap.
   function automatic logic [LEN_W:0] blocks_needed(input logic [LEN_W-1:0] len);
      logic [LEN_W:0] sum;
      sum = {1'b0, len} + (LEN_W+1)'(BLOCK_W + LEN_W);
      return sum >> R_W;
   endfunction

endpackage

// File: rtl/message_mask.sv
// ----------------------------------------------------------------------------
// message_mask
// Keeps the top r bits of a block and zeroes the rest, which also removes the
// '1' pad bit that follows the message data.
//   block    in  BLOCK_W  block to mask, MSB-first
//   r        in  R_W      number of leading bits to keep (0 keeps nothing)
//   zero_all in  1        force an all-zero result
//   masked   out BLOCK_W  masked block
// ----------------------------------------------------------------------------
module message_mask
   import message_pkg::*;
(
   input  logic [BLOCK_W-1:0] block,
   input  logic [R_W-1:0]     r,
   input  logic               zero_all,
   output logic [BLOCK_W-1:0] masked
);

   logic [BLOCK_W-1:0] keep;

   always_comb begin
      keep   = ~({BLOCK_W{1'b1}} >> r);
      masked = zero_all ? '0 : (block & keep);
   end

endmodule

// File: rtl/message_strip.sv
// ----------------------------------------------------------------------------
// message_strip
// Removes SHA-2 padding from a stream of 512-bit blocks, emitting the message
// chunks (tail bits zeroed) and the recovered bit length.
//   clk            in  1        clock, rising edge
//   nrst           in  1        asynchronous active-low reset
//   sync_rst       in  1        synchronous clear, same effect as nrst
//   data_in        in  BLOCK_W  padded block, MSB-first
//   data_in_last   in  1        final block (carries the length field)
//   data_in_valid  in  1        input handshake
//   data_in_ready  out 1
//   data_out       out BLOCK_W  recovered message chunk
//   data_out_last  out 1        final chunk of the message
//   data_out_valid out 1        output handshake
//   data_out_ready in  1
//   size_out       out LEN_W    message length in bits
//   size_out_valid out 1        size handshake
//   size_out_ready in  1
//   err            out 1        one-cycle pulse on a framing error
// ----------------------------------------------------------------------------
module message_strip
   import message_pkg::*;
(
   input  logic               clk,
   input  logic               nrst,
   input  logic               sync_rst,
   input  logic [BLOCK_W-1:0] data_in,
   input  logic               data_in_last,
   input  logic               data_in_valid,
   output logic               data_in_ready,
   output logic [BLOCK_W-1:0] data_out,
   output logic               data_out_last,
   output logic               data_out_valid,
   input  logic               data_out_ready,
   output logic [LEN_W-1:0]   size_out,
   output logic               size_out_valid,
   input  logic               size_out_ready,
   output logic               err
);

   msg_state_t         state;
   logic [BLOCK_W-1:0] held;
   logic [LEN_W-1:0]   blk_cnt;

   logic [LEN_W-1:0]   len;
   logic [R_W-1:0]     r;
   logic               len_zero;
   logic               r_zero;
   logic               r_pad;
   logic               r_mid;
   logic               slot_free;
   logic               acc;
   logic               acc_last;
   logic [LEN_W-1:0]   cnt_inc;
   logic               count_bad;
   logic               empty_bad;
   logic [BLOCK_W-1:0] mask_src;
   logic               zero_all;
   logic [BLOCK_W-1:0] masked;

   assign len       = data_in[LEN_W-1:0];
   assign r         = len[R_W-1:0];
   assign len_zero  = (len == '0);
   assign r_zero    = (r == '0);
   assign r_pad     = (r >= R_W'(PAD_LIMIT));
   assign r_mid     = !r_zero && !r_pad;
   assign slot_free = !data_out_valid || data_out_ready;
   assign acc       = data_in_valid && data_in_ready;
   assign acc_last  = acc && data_in_last;
   assign cnt_inc   = blk_cnt + 1'b1;
   assign count_bad = ({1'b0, cnt_inc} != blocks_needed(len));
   assign empty_bad = (state == ST_EMPTY) && ((r_zero && !len_zero) || r_pad);

   // A final block can only be taken once the previous length was consumed.
   always_comb begin
      data_in_ready = 1'b0;
      if (state != ST_LAST_PEND)
         data_in_ready = slot_free && !(data_in_last && size_out_valid);
   end

   // One mask instance is shared: in HELD with r >= PAD_LIMIT the held block
   // is trimmed, every other masking case trims the incoming final block.
   // A single-block message with r >= PAD_LIMIT is malformed and emits zeros;
   // r = 0 already yields zeros through the mask itself.
   always_comb begin
      mask_src = data_in;
      if (state == ST_HELD && r_pad)
         mask_src = held;
      zero_all = (state == ST_EMPTY) && r_pad;
   end

   message_mask u_mask (
      .block    (mask_src),
      .r        (r),
      .zero_all (zero_all),
      .masked   (masked)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state          <= ST_EMPTY;
         held           <= '0;
         blk_cnt        <= '0;
         data_out       <= '0;
         data_out_last  <= 1'b0;
         data_out_valid <= 1'b0;
         size_out       <= '0;
         size_out_valid <= 1'b0;
         err            <= 1'b0;
      end else if (sync_rst) begin
         state          <= ST_EMPTY;
         held           <= '0;
         blk_cnt        <= '0;
         data_out       <= '0;
         data_out_last  <= 1'b0;
         data_out_valid <= 1'b0;
         size_out       <= '0;
         size_out_valid <= 1'b0;
         err            <= 1'b0;
      end else begin
         if (data_out_ready)
            data_out_valid <= 1'b0;
         if (size_out_ready)
            size_out_valid <= 1'b0;

         err <= acc_last && (count_bad || empty_bad);

         if (acc) begin
            blk_cnt <= data_in_last ? '0 : cnt_inc;
         end

         if (acc_last) begin
            size_out       <= len;
            size_out_valid <= 1'b1;
         end

         unique case (state)
            ST_EMPTY: begin
               if (acc) begin
                  if (data_in_last) begin
                     data_out       <= masked;
                     data_out_last  <= 1'b1;
                     data_out_valid <= 1'b1;
                  end else begin
                     held  <= data_in;
                     state <= ST_HELD;
                  end
               end
            end
            ST_HELD: begin
               if (acc) begin
                  data_out_valid <= 1'b1;
                  if (!data_in_last) begin
                     data_out      <= held;
                     data_out_last <= 1'b0;
                     held          <= data_in;
                  end else if (r_mid) begin
                     data_out      <= held;
                     data_out_last <= 1'b0;
                     held          <= masked;
                     state         <= ST_LAST_PEND;
                  end else if (r_pad) begin
                     data_out      <= masked;
                     data_out_last <= 1'b1;
                     state         <= ST_EMPTY;
                  end else begin
                     data_out      <= held;
                     data_out_last <= 1'b1;
                     state         <= ST_EMPTY;
                  end
               end
            end
            ST_LAST_PEND: begin
               if (slot_free) begin
                  data_out       <= held;
                  data_out_last  <= 1'b1;
                  data_out_valid <= 1'b1;
                  state          <= ST_EMPTY;
               end
            end
            default: state <= ST_EMPTY;
         endcase
      end
   end

endmodule
